// File: rtl/core_clk_mon.sv
// Divided-clock monitor: samples the pipe and SRAM divided clocks in the clk domain,
// checks each half-period against its nominal length and runs a lock/fault FSM.
module core_clk_mon #(
  parameter int unsigned PIPE_HALF = 10,
  parameter int unsigned SRAM_HALF = 1,
  parameter int unsigned LOCK_CNT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pipe_clk_in,
  input  logic       sram_clk_in,
  input  logic       clr_err,
  output logic       locked,
  output logic [1:0] state,
  output logic       pipe_err,
  output logic       sram_err,
  output logic       stuck_err,
  output logic       fault_irq,
  output logic [7:0] pipe_period
);

  localparam logic [7:0] PIPE_HALF_C = 8'(PIPE_HALF);
  localparam logic [7:0] SRAM_HALF_C = 8'(SRAM_HALF);
  localparam logic [2:0] LOCK_CNT_C  = 3'(LOCK_CNT);
  localparam logic [7:0] CNT_MAX     = 8'hFF;
  localparam logic [2:0] GOOD_MAX    = 3'h7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic       locked_q, locked_d;
  logic       fault_irq_q, fault_irq_d;

  logic       pipe_prev_q, pipe_prev_d;
  logic       sram_prev_q, sram_prev_d;
  logic       pipe_armed_q, pipe_armed_d;
  logic       sram_armed_q, sram_armed_d;
  logic [7:0] pipe_cnt_q, pipe_cnt_d;
  logic [7:0] sram_cnt_q, sram_cnt_d;

  logic       pipe_err_q, pipe_err_d;
  logic       sram_err_q, sram_err_d;
  logic       stuck_err_q, stuck_err_d;
  logic [7:0] pipe_period_q, pipe_period_d;
  logic [2:0] good_cnt_q, good_cnt_d;

  logic       clr_fire_s;
  logic       pipe_tog_s, sram_tog_s;
  logic [7:0] pipe_meas_s;
  logic       pipe_good_s;
  logic       pipe_det_s, sram_det_s, stuck_det_s;
  logic       any_err_s;

  function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic tog,
                                          input logic clr);
    logic [7:0] nxt;
    if (clr) begin
      nxt = 8'd0;
    end else if (tog) begin
      nxt = 8'd0;
    end else if (cnt == CNT_MAX) begin
      nxt = cnt;
    end else begin
      nxt = cnt + 8'd1;
    end
    return nxt;
  endfunction

  function automatic logic armed_next(input logic armed, input logic tog, input logic clr);
    logic nxt;
    if (clr) begin
      nxt = 1'b0;
    end else if (tog) begin
      nxt = 1'b1;
    end else begin
      nxt = armed;
    end
    return nxt;
  endfunction

  // An armed channel errs on a wrong-length toggle, or when a toggle is overdue.
  function automatic logic err_detect(input logic armed, input logic tog,
                                      input logic [7:0] cnt, input logic [7:0] half);
    logic       det;
    logic [7:0] meas;
    meas = cnt + 8'd1;
    if (!armed) begin
      det = 1'b0;
    end else if (tog) begin
      det = (meas != half);
    end else begin
      det = (cnt == half);
    end
    return det;
  endfunction

  // Per-channel edge detection, half-period counting and error detection
  always_comb begin
    clr_fire_s   = clr_err & (state_q == ST_FAULT);
    pipe_prev_d  = pipe_clk_in;
    sram_prev_d  = sram_clk_in;
    pipe_tog_s   = pipe_clk_in ^ pipe_prev_q;
    sram_tog_s   = sram_clk_in ^ sram_prev_q;
    pipe_meas_s  = pipe_cnt_q + 8'd1;
    pipe_good_s  = pipe_armed_q & pipe_tog_s & (pipe_meas_s == PIPE_HALF_C);
    pipe_cnt_d   = cnt_next(pipe_cnt_q, pipe_tog_s, clr_fire_s);
    sram_cnt_d   = cnt_next(sram_cnt_q, sram_tog_s, clr_fire_s);
    pipe_armed_d = armed_next(pipe_armed_q, pipe_tog_s, clr_fire_s);
    sram_armed_d = armed_next(sram_armed_q, sram_tog_s, clr_fire_s);
    pipe_det_s   = err_detect(pipe_armed_q, pipe_tog_s, pipe_cnt_q, PIPE_HALF_C);
    sram_det_s   = err_detect(sram_armed_q, sram_tog_s, sram_cnt_q, SRAM_HALF_C);
    stuck_det_s  = (~pipe_armed_q & (pipe_cnt_q == CNT_MAX)) |
                   (~sram_armed_q & (sram_cnt_q == CNT_MAX));
  end

  // Sticky flags, last pipe measurement and good-measurement counter
  always_comb begin
    if (clr_fire_s) begin
      pipe_err_d  = 1'b0;
      sram_err_d  = 1'b0;
      stuck_err_d = 1'b0;
    end else begin
      pipe_err_d  = pipe_err_q | pipe_det_s;
      sram_err_d  = sram_err_q | sram_det_s;
      stuck_err_d = stuck_err_q | stuck_det_s;
    end
    any_err_s = pipe_err_d | sram_err_d | stuck_err_d;

    if (pipe_tog_s && pipe_armed_q) begin
      pipe_period_d = pipe_meas_s;
    end else begin
      pipe_period_d = pipe_period_q;
    end

    if (clr_fire_s) begin
      good_cnt_d = 3'd0;
    end else if ((state_q == ST_ACQ) && pipe_good_s && (good_cnt_q != GOOD_MAX)) begin
      good_cnt_d = good_cnt_q + 3'd1;
    end else begin
      good_cnt_d = good_cnt_q;
    end
  end

  // Next-state logic; a new error wins over lock in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stuck_err_d) begin
          state_d = ST_FAULT;
        end else if (pipe_armed_q && sram_armed_q) begin
          state_d = ST_ACQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACQ: begin
        if (any_err_s) begin
          state_d = ST_FAULT;
        end else if (good_cnt_d == LOCK_CNT_C) begin
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_ACQ;
        end
      end
      ST_LOCKED: begin
        if (any_err_s) begin
          state_d = ST_FAULT;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_FAULT: begin
        if (clr_err) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs come straight from flops
  always_comb begin
    locked_d    = (state_d == ST_LOCKED);
    fault_irq_d = (state_d == ST_FAULT) & (state_q != ST_FAULT);
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      locked_q    <= 1'b0;
      fault_irq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      fault_irq_q <= fault_irq_d;
    end
  end

  // Channel and measurement registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_prev_q   <= 1'b0;
      sram_prev_q   <= 1'b0;
      pipe_armed_q  <= 1'b0;
      sram_armed_q  <= 1'b0;
      pipe_cnt_q    <= 8'd0;
      sram_cnt_q    <= 8'd0;
      pipe_err_q    <= 1'b0;
      sram_err_q    <= 1'b0;
      stuck_err_q   <= 1'b0;
      pipe_period_q <= 8'd0;
      good_cnt_q    <= 3'd0;
    end else begin
      pipe_prev_q   <= pipe_prev_d;
      sram_prev_q   <= sram_prev_d;
      pipe_armed_q  <= pipe_armed_d;
      sram_armed_q  <= sram_armed_d;
      pipe_cnt_q    <= pipe_cnt_d;
      sram_cnt_q    <= sram_cnt_d;
      pipe_err_q    <= pipe_err_d;
      sram_err_q    <= sram_err_d;
      stuck_err_q   <= stuck_err_d;
      pipe_period_q <= pipe_period_d;
      good_cnt_q    <= good_cnt_d;
    end
  end

  assign state       = state_q;
  assign locked      = locked_q;
  assign fault_irq   = fault_irq_q;
  assign pipe_err    = pipe_err_q;
  assign sram_err    = sram_err_q;
  assign stuck_err   = stuck_err_q;
  assign pipe_period = pipe_period_q;

endmodule

// File: tb/tb_core_clk_mon.sv
// Scoreboard bench for core_clk_mon: stimulus queues cycle-tagged expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_core_clk_mon;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pipe_clk_in = 1'b0;
  logic       sram_clk_in = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic [1:0] state;
  logic       pipe_err;
  logic       sram_err;
  logic       stuck_err;
  logic       fault_irq;
  logic [7:0] pipe_period;

  core_clk_mon #(.PIPE_HALF(10), .SRAM_HALF(1), .LOCK_CNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_clk_in(pipe_clk_in), .sram_clk_in(sram_clk_in),
    .clr_err(clr_err), .locked(locked), .state(state), .pipe_err(pipe_err),
    .sram_err(sram_err), .stuck_err(stuck_err), .fault_irq(fault_irq),
    .pipe_period(pipe_period)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [95:0] name;
    logic [14:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   finishing = 1'b0;
  bit   mon_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected = {state, locked, pipe_err, sram_err, stuck_err, fault_irq, pipe_period}
  task automatic expect_at(input int at, input logic [95:0] nm, input logic [1:0] st,
                           input logic lk, input logic pe, input logic se, input logic ste,
                           input logic irq, input logic [7:0] per);
    exp_t e;
    int   pos;
    e.cyc  = at;
    e.name = nm;
    e.exp  = {st, lk, pe, se, ste, irq, per};
    pos = sb.size();
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > at) pos = i;
    sb.insert(pos, e);
  endtask

  // n cycles of one pipe half; sram toggles every cycle except at hold_at
  task automatic run(input int n, input bit tog_pipe, input int clr_at, input int hold_at);
    if (tog_pipe) pipe_clk_in = ~pipe_clk_in;
    for (int i = 0; i < n; i++) begin
      if (i != hold_at) sram_clk_in = ~sram_clk_in;
      clr_err = (i == clr_at);
      @(posedge clk);
      #1;
    end
    clr_err = 1'b0;
  endtask

  initial begin : monitor
    exp_t        e;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      act = {state, locked, pipe_err, sram_err, stuck_err, fault_irq, pipe_period};
      while (sb.size() > 0 && (sb[0].cyc <= cyc || finishing)) begin
        e = sb.pop_front();
        total++;
        if (e.cyc != cyc) begin
          bad++;
          $display("FAIL %0s: expected at cyc %0d, not sampled (now %0d) required=%b/%0d",
                   e.name, e.cyc, cyc, e.exp[14:8], e.exp[7:0]);
        end else if (act !== e.exp) begin
          bad++;
          $display("FAIL %0s cyc=%0d actual st,lk,pe,se,ste,irq=%b period=%0d required=%b period=%0d",
                   e.name, cyc, act[14:8], act[7:0], e.exp[14:8], e.exp[7:0]);
        end
      end
      if (finishing) mon_done = 1'b1;
    end
  end

  initial begin : stimulus
    int c0;
    int cs;
    int r;
    repeat (3) @(posedge clk);
    #1;
    c0 = cyc;
    expect_at(c0, "reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // nominal lock: lock one cycle after the 5th pipe toggle
    expect_at(c0 + 1,  "idle_arm",  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(c0 + 2,  "acq",       2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(c0 + 40, "acq_late",  2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    expect_at(c0 + 41, "lock",      2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    repeat (6) run(10, 1'b1, -1, -1);

    // short pipe half of 9
    cs = cyc;
    expect_at(cs + 9,  "pre_short", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    expect_at(cs + 10, "pipe_err",  2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd9);
    expect_at(cs + 11, "irq_pulse", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
    run(9, 1'b1, -1, -1);
    run(10, 1'b1, -1, -1);

    // clear from FAULT, then relock after 5 further toggles
    cs = cyc;
    expect_at(cs + 3,  "fault_hold", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
    expect_at(cs + 4,  "clr_idle",   2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    expect_at(cs + 50, "reacq",      2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    expect_at(cs + 51, "relock",     2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    run(10, 1'b1, 3, -1);
    repeat (5) run(10, 1'b1, -1, -1);

    // clr_err while LOCKED has no effect
    cs = cyc;
    expect_at(cs + 3, "clr_ignored", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    run(10, 1'b1, 2, -1);

    // sram held for 2 cycles
    cs = cyc;
    expect_at(cs + 5,  "sram_pre",    2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    expect_at(cs + 6,  "sram_err",    2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd10);
    expect_at(cs + 7,  "sram_irq0",   2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10);
    expect_at(cs + 15, "sram_sticky", 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10);
    run(10, 1'b1, -1, 4);
    run(10, 1'b1, -1, -1);

    // clear in the same cycle as a pipe toggle, relock, then async reset
    cs = cyc;
    expect_at(cs + 1,  "clr2_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    expect_at(cs + 51, "relock2",   2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd10);
    run(10, 1'b1, 0, -1);
    repeat (5) run(10, 1'b1, -1, -1);
    rst_n = 1'b0;
    expect_at(cyc, "async_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    pipe_clk_in = 1'b0;
    sram_clk_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // pipe stuck after reset
    r = cyc;
    expect_at(r + 255, "pre_stuck", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    expect_at(r + 256, "stuck",     2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
    expect_at(r + 257, "stuck_irq", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    rst_n = 1'b1;
    run(260, 1'b0, -1, -1);

    finishing = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
